// File: rtl/rv32i_types_pkg.sv
// Shared RV32I scalar types used across the pipeline.
// Provides word_t (32-bit machine word).
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/stage5_arb_pkg.sv
// Types for the fetch/data memory bus arbiter.
// Holds the FSM state enum and the latched bus request bundle.
package stage5_arb_pkg;

  import rv32i_types_pkg::word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2
  } arb_state_t;

  typedef struct packed {
    word_t      addr;
    word_t      wdata;
    logic [3:0] byte_en;
    logic       ren;
    logic       wen;
  } arb_req_t;

  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/stage5_mem_arbiter.sv
// Arbitrates one memory bus between fetch reads and mem-stage loads/stores.
// Ports: CLK/RST, fetch req (iren/iaddr/irdata/i_mem_busy),
// data req (dren/dwen/daddr/dwdata/dbyte_en/drdata/d_mem_busy),
// bus side (bus_ren/bus_wen/bus_addr/bus_wdata/bus_byte_en/bus_rdata/bus_busy).
module stage5_mem_arbiter
  import rv32i_types_pkg::*;
  import stage5_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       iren,
  input  word_t      iaddr,
  output word_t      irdata,
  output logic       i_mem_busy,
  input  logic       dren,
  input  logic       dwen,
  input  word_t      daddr,
  input  word_t      dwdata,
  input  logic [3:0] dbyte_en,
  output word_t      drdata,
  output logic       d_mem_busy,
  output logic       bus_ren,
  output logic       bus_wen,
  output word_t      bus_addr,
  output word_t      bus_wdata,
  output logic [3:0] bus_byte_en,
  input  word_t      bus_rdata,
  input  logic       bus_busy
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  arb_state_t    state, state_n;
  arb_req_t      lat, lat_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          i_drop, i_drop_n;
  logic          d_drop, d_drop_n;

  logic d_req;
  logic xfer;
  logic xfer_done;
  logic arb_ok;
  logic grant_i;
  logic grant_d;
  logic i_match;
  logic d_match;

  assign d_req     = dren | dwen;
  assign xfer      = (state != IDLE);
  assign xfer_done = xfer & ~bus_busy;
  assign arb_ok    = (state == IDLE) | xfer_done;

  // Data wins unless fetch has been passed over STARVE_MAX times.
  assign grant_i = arb_ok & iren
                 & (~d_req | (cnt == CNT_MAX));
  assign grant_d = arb_ok & d_req & ~grant_i;

  // Live match against the latched request; a mismatch abandons it.
  assign i_match = iren & (iaddr == lat.addr);
  assign d_match = d_req
                 & (daddr == lat.addr)
                 & (dren == lat.ren)
                 & (dwen == lat.wen);

  always_comb begin
    state_n  = state;
    lat_n    = lat;
    cnt_n    = cnt;
    i_drop_n = i_drop;
    d_drop_n = d_drop;

    if (state == I_XFER)
      i_drop_n = xfer_done ? 1'b0 : (i_drop | ~i_match);
    if (state == D_XFER)
      d_drop_n = xfer_done ? 1'b0 : (d_drop | ~d_match);

    if (xfer_done)
      state_n = IDLE;

    unique case (1'b1)
      grant_i: begin
        state_n = I_XFER;
        lat_n   = '{addr: iaddr, wdata: '0,
                    byte_en: FETCH_BE,
                    ren: 1'b1, wen: 1'b0};
        cnt_n   = '0;
      end
      grant_d: begin
        state_n = D_XFER;
        lat_n   = '{addr: daddr, wdata: dwdata,
                    byte_en: dbyte_en,
                    ren: dren, wen: dwen};
        if (iren && cnt != CNT_MAX)
          cnt_n = cnt + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      lat    <= '0;
      cnt    <= '0;
      i_drop <= 1'b0;
      d_drop <= 1'b0;
    end else begin
      state  <= state_n;
      lat    <= lat_n;
      cnt    <= cnt_n;
      i_drop <= i_drop_n;
      d_drop <= d_drop_n;
    end
  end

  assign bus_ren     = xfer & lat.ren;
  assign bus_wen     = xfer & lat.wen;
  assign bus_addr    = xfer ? lat.addr : '0;
  assign bus_wdata   = xfer ? lat.wdata : '0;
  assign bus_byte_en = xfer ? lat.byte_en : '0;

  assign i_mem_busy = iren & ~((state == I_XFER)
                    & ~bus_busy & ~i_drop & i_match);
  assign d_mem_busy = d_req & ~((state == D_XFER)
                    & ~bus_busy & ~d_drop & d_match);

  assign irdata = bus_rdata;
  assign drdata = bus_rdata;

endmodule

// File: tb/tb_stage5_mem_arbiter.sv
// Directed bench for stage5_mem_arbiter with STARVE_MAX=2.
// Inputs change 1ns after the rising edge; outputs checked mid-cycle.
module tb_stage5_mem_arbiter;

  logic        CLK;
  logic        RST;
  logic        iren;
  logic [31:0] iaddr;
  logic [31:0] irdata;
  logic        i_mem_busy;
  logic        dren;
  logic        dwen;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dbyte_en;
  logic [31:0] drdata;
  logic        d_mem_busy;
  logic        bus_ren;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_rdata;
  logic        bus_busy;

  int errors = 0;
  int checks = 0;

  stage5_mem_arbiter #(.STARVE_MAX(2)) dut (
    .CLK(CLK), .RST(RST),
    .iren(iren), .iaddr(iaddr), .irdata(irdata),
    .i_mem_busy(i_mem_busy),
    .dren(dren), .dwen(dwen), .daddr(daddr),
    .dwdata(dwdata), .dbyte_en(dbyte_en),
    .drdata(drdata), .d_mem_busy(d_mem_busy),
    .bus_ren(bus_ren), .bus_wen(bus_wen),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_byte_en(bus_byte_en), .bus_rdata(bus_rdata),
    .bus_busy(bus_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    iren = 0; iaddr = 0;
    dren = 0; dwen = 0; daddr = 0;
    dwdata = 0; dbyte_en = 0;
    bus_rdata = 0; bus_busy = 1'b1;
    nxt();
    nxt();
    #1;
    chk("rst_ren", 32'(bus_ren), 0);
    chk("rst_wen", 32'(bus_wen), 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_be", 32'(bus_byte_en), 0);
    chk("rst_ibusy", 32'(i_mem_busy), 0);
    chk("rst_dbusy", 32'(d_mem_busy), 0);
    RST = 1'b0;

    // fetch alone, bus busy for 2 cycles
    nxt();
    iren = 1; iaddr = 32'h100;
    #1;
    chk("f_c0_ibusy", 32'(i_mem_busy), 1);
    chk("f_c0_ren", 32'(bus_ren), 0);
    nxt();
    #1;
    chk("f_c1_ren", 32'(bus_ren), 1);
    chk("f_c1_addr", bus_addr, 32'h100);
    chk("f_c1_be", 32'(bus_byte_en), 32'hF);
    chk("f_c1_ibusy", 32'(i_mem_busy), 1);
    nxt();
    #1;
    chk("f_c2_ibusy", 32'(i_mem_busy), 1);
    nxt();
    bus_busy = 0; bus_rdata = 32'hCAFEF00D;
    #1;
    chk("f_c3_ibusy", 32'(i_mem_busy), 0);
    chk("f_c3_irdata", irdata, 32'hCAFEF00D);
    iren = 0;
    nxt();
    bus_busy = 1;
    #1;
    chk("f_c4_ren", 32'(bus_ren), 0);

    // simultaneous fetch + data write
    nxt();
    iren = 1; iaddr = 32'h200;
    dwen = 1; daddr = 32'h8000;
    dwdata = 32'hDEADBEEF; dbyte_en = 4'h3;
    nxt();
    #1;
    chk("s_c1_wen", 32'(bus_wen), 1);
    chk("s_c1_ren", 32'(bus_ren), 0);
    chk("s_c1_be", 32'(bus_byte_en), 32'h3);
    chk("s_c1_addr", bus_addr, 32'h8000);
    chk("s_c1_wdata", bus_wdata, 32'hDEADBEEF);
    chk("s_c1_dbusy", 32'(d_mem_busy), 1);
    chk("s_c1_ibusy", 32'(i_mem_busy), 1);
    nxt();
    bus_busy = 0;
    #1;
    chk("s_c2_dbusy", 32'(d_mem_busy), 0);
    chk("s_c2_ibusy", 32'(i_mem_busy), 1);
    dwen = 0;
    nxt();
    bus_busy = 1;
    #1;
    chk("s_c3_ren", 32'(bus_ren), 1);
    chk("s_c3_wen", 32'(bus_wen), 0);
    chk("s_c3_addr", bus_addr, 32'h200);
    nxt();
    bus_busy = 0;
    #1;
    chk("s_c4_ibusy", 32'(i_mem_busy), 0);
    iren = 0;
    nxt();
    bus_busy = 1;
    #1;
    chk("s_c5_ren", 32'(bus_ren), 0);

    // starvation: data held, single-cycle bus
    nxt();
    iren = 1; iaddr = 32'h500;
    dren = 1; daddr = 32'h600;
    bus_busy = 0;
    nxt();
    #1;
    chk("st_g1_addr", bus_addr, 32'h600);
    chk("st_g1_dbusy", 32'(d_mem_busy), 0);
    nxt();
    #1;
    chk("st_g2_addr", bus_addr, 32'h600);
    chk("st_g2_ibusy", 32'(i_mem_busy), 1);
    nxt();
    #1;
    chk("st_g3_addr", bus_addr, 32'h500);
    chk("st_g3_ibusy", 32'(i_mem_busy), 0);
    chk("st_g3_dbusy", 32'(d_mem_busy), 1);
    iren = 0; dren = 0;
    nxt();
    bus_busy = 1;
    #1;
    chk("st_idle_ren", 32'(bus_ren), 0);

    // fetch flush mid-transfer
    nxt();
    iren = 1; iaddr = 32'h300;
    nxt();
    #1;
    chk("fl_c1_addr", bus_addr, 32'h300);
    iaddr = 32'h400;
    #1;
    chk("fl_c1_ibusy", 32'(i_mem_busy), 1);
    nxt();
    bus_busy = 0;
    #1;
    chk("fl_c2_ibusy", 32'(i_mem_busy), 1);
    chk("fl_c2_addr", bus_addr, 32'h300);
    nxt();
    bus_busy = 1;
    #1;
    chk("fl_c3_addr", bus_addr, 32'h400);
    chk("fl_c3_ren", 32'(bus_ren), 1);
    nxt();
    bus_busy = 0;
    #1;
    chk("fl_c4_ibusy", 32'(i_mem_busy), 0);
    iren = 0;
    nxt();
    bus_busy = 1;

    // async reset mid data write
    nxt();
    dwen = 1; daddr = 32'h900;
    dwdata = 32'h1; dbyte_en = 4'hF;
    nxt();
    #1;
    chk("r_c1_wen", 32'(bus_wen), 1);
    RST = 1;
    #1;
    chk("r_async_wen", 32'(bus_wen), 0);
    chk("r_async_addr", bus_addr, 0);
    dwen = 0;
    nxt();
    RST = 0;
    #1;
    chk("r_rel_wen", 32'(bus_wen), 0);
    chk("r_rel_ren", 32'(bus_ren), 0);
    chk("r_rel_dbusy", 32'(d_mem_busy), 0);
    nxt();
    #1;
    chk("r_idle_wen", 32'(bus_wen), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
